// File: rtl/exc_ctrl.sv
// MEM-stage exception/interrupt controller: prioritises exceptions, drives CP0 type, flush, redirect PC and stalls.
// Optional macro EXC_PEND_INT_EN keeps an interrupt raised during a bubble pending until a real instruction arrives.
module exc_ctrl #(
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
   parameter int          FLUSH_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid_i,
   input  logic [4:0]  exc_flags_i,
   input  logic [31:0] current_inst_addr_i,
   input  logic [31:0] cp0_status_i,
   input  logic [31:0] cp0_cause_i,
   input  logic [31:0] cp0_epc_i,
   input  logic        wb_cp0_we_i,
   input  logic [4:0]  wb_cp0_waddr_i,
   input  logic [31:0] wb_cp0_data_i,
   input  logic        stallreq_id_i,
   input  logic        stallreq_ex_i,
   output logic [31:0] excepttype_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o,
   output logic [5:0]  stall_o
);

   typedef enum logic {S_IDLE, S_FLUSH} state_t;

   localparam logic [31:0] EXC_NONE     = 32'h0;
   localparam logic [31:0] EXC_INT      = 32'h1;
   localparam logic [31:0] EXC_SYSCALL  = 32'h8;
   localparam logic [31:0] EXC_INVALID  = 32'ha;
   localparam logic [31:0] EXC_TRAP     = 32'hd;
   localparam logic [31:0] EXC_OVERFLOW = 32'hc;
   localparam logic [31:0] EXC_ERET     = 32'he;
   localparam logic [1:0]  CNT_INIT     = 2'(FLUSH_CYCLES - 1);

   state_t      state;
   logic [1:0]  cnt;
   logic [31:0] pc_lat;

   logic [31:0] status_eff, cause_eff, epc_eff;
   logic        int_mask_ok, int_cond, int_take, idle_hit;
   logic [31:0] exc_code, redirect_pc;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      status_eff = cp0_status_i;
      epc_eff    = cp0_epc_i;
      cause_eff  = cp0_cause_i;
      if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) status_eff = wb_cp0_data_i;
      if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) epc_eff = wb_cp0_data_i;
      if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13) begin
         cause_eff[9:8]   = wb_cp0_data_i[9:8];
         cause_eff[23:22] = wb_cp0_data_i[23:22];
      end
   end

   assign int_mask_ok = status_eff[0] && !status_eff[1];
   assign int_cond    = (|(cause_eff[15:8] & status_eff[15:8])) && int_mask_ok;

`ifdef EXC_PEND_INT_EN
   logic int_pend;

   // Mask check on the pending path lets a same-cycle IE clear suppress the interrupt.
   assign int_take = mem_valid_i && (int_cond || (int_pend && int_mask_ok));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         int_pend <= 1'b0;
      else if ((idle_hit && exc_code == EXC_INT) || !int_mask_ok)
         int_pend <= 1'b0;
      else if (int_cond && !mem_valid_i)
         int_pend <= 1'b1;
   end
`else
   assign int_take = mem_valid_i && int_cond;
`endif

   always_comb begin
      exc_code = EXC_NONE;
      if (mem_valid_i) begin
         if (int_take)            exc_code = EXC_INT;
         else if (exc_flags_i[0]) exc_code = EXC_SYSCALL;
         else if (exc_flags_i[1]) exc_code = EXC_INVALID;
         else if (exc_flags_i[2]) exc_code = EXC_TRAP;
         else if (exc_flags_i[3]) exc_code = EXC_OVERFLOW;
         else if (exc_flags_i[4]) exc_code = EXC_ERET;
      end
   end

   assign redirect_pc = (exc_code == EXC_ERET) ? epc_eff : EXC_VECTOR;

   // Outputs are gated by rst so that asserting reset mid-flush silences them at once.
   assign idle_hit     = rst && (state == S_IDLE) && (exc_code != EXC_NONE);
   assign excepttype_o = idle_hit ? exc_code : EXC_NONE;
   assign flush_o      = rst && ((state == S_FLUSH) || idle_hit);

   always_comb begin
      new_pc_o = 32'h0;
      stall_o  = 6'b000000;
      if (rst) begin
         if (state == S_FLUSH)   new_pc_o = pc_lat;
         else if (idle_hit)      new_pc_o = redirect_pc;
         if (!flush_o) begin
            if (stallreq_ex_i)      stall_o = 6'b001111;
            else if (stallreq_id_i) stall_o = 6'b000111;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst) begin
         state  <= S_IDLE;
         cnt    <= 2'd0;
         pc_lat <= 32'h0;
      end else begin
         case (state)
            S_IDLE: begin
               if (idle_hit) begin
                  pc_lat <= redirect_pc;
                  if (FLUSH_CYCLES > 1) begin
                     state <= S_FLUSH;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            S_FLUSH: begin
               if (cnt <= 2'd1) begin
                  state <= S_IDLE;
                  cnt   <= 2'd0;
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // CP0 samples the faulting PC itself; the remaining register bits carry no meaning here.
   logic unused_bits;
   assign unused_bits = ^{current_inst_addr_i, cause_eff[31:16], cause_eff[7:0],
                          status_eff[31:16], status_eff[7:2]};

endmodule
